// File: rtl/morse_rx_core.sv
// Morse receiver core: turns debounced button presses and external timer flags
// into decoded character strobes (A..Z = 0..25, 0..9 = 26..35, space = 36, unknown = 63).
//
// state     | meaning
// IDLE      | waiting for the first press of a character
// PRESS     | button held; dash timer and press-too-long timer running
// LOCKOUT   | press timed out; wait for release, discard the character
// GAP       | between elements; inter-character timer running
// EMIT      | character strobe visible; buffer is cleared here
// WORD_WAIT | after a character; word timer running
module morse_rx_core (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       user_btn,
    input  logic       btn_to,
    input  logic       dash_to,
    input  logic       inter_to,
    input  logic       word_to,
    output logic       btn_to_res,
    output logic       dash_to_res,
    output logic       inter_to_res,
    output logic       word_to_res,
    output logic [5:0] char_data,
    output logic       char_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_LOCKOUT,
        S_GAP,
        S_EMIT,
        S_WORD_WAIT
    } state_t;

    localparam logic [5:0] CODE_SPACE   = 6'd36;
    localparam logic [5:0] CODE_INVALID = 6'd63;
    localparam logic [2:0] CNT_MAX      = 3'd6;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_buf;
    logic [2:0] r_cnt;
    logic [5:0] r_char_data;
    logic       r_char_valid;
    logic [5:0] w_code;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (user_btn) w_next = S_PRESS;
            end
            S_PRESS: begin
                if (btn_to)         w_next = S_LOCKOUT;
                else if (!user_btn) w_next = S_GAP;
            end
            S_LOCKOUT: begin
                if (!user_btn) w_next = S_IDLE;
            end
            S_GAP: begin
                if (inter_to)      w_next = S_EMIT;
                else if (user_btn) w_next = S_PRESS;
            end
            S_EMIT: begin
                w_next = user_btn ? S_PRESS : S_WORD_WAIT;
            end
            S_WORD_WAIT: begin
                if (user_btn)     w_next = S_PRESS;
                else if (word_to) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        btn_to_res   = 1'b1;
        dash_to_res  = 1'b1;
        inter_to_res = 1'b1;
        word_to_res  = 1'b1;
        case (r_state)
            S_PRESS: begin
                btn_to_res  = 1'b0;
                dash_to_res = 1'b0;
            end
            S_GAP:       inter_to_res = 1'b0;
            S_WORD_WAIT: word_to_res  = 1'b0;
            default: ;
        endcase
    end

    // The strobe is registered on the edge entering EMIT so it is high while in EMIT.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_char_data  <= '0;
            r_char_valid <= 1'b0;
        end else begin
            r_char_valid <= 1'b0;
            case (r_state)
                S_PRESS: begin
                    if (btn_to) begin
                        r_buf <= '0;
                        r_cnt <= '0;
                    end else if (!user_btn) begin
                        r_buf <= {r_buf[3:0], dash_to};
                        r_cnt <= (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 3'd1;
                    end
                end
                S_GAP: begin
                    if (inter_to) begin
                        r_char_data  <= w_code;
                        r_char_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    r_buf <= '0;
                    r_cnt <= '0;
                end
                S_WORD_WAIT: begin
                    if (!user_btn && word_to) begin
                        r_char_data  <= CODE_SPACE;
                        r_char_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key is {element count, elements}; first element sits at bit (count-1).
    always_comb begin
        w_code = CODE_INVALID;
        case ({r_cnt, r_buf})
            {3'd1, 5'b00000}: w_code = 6'd4;
            {3'd1, 5'b00001}: w_code = 6'd19;
            {3'd2, 5'b00001}: w_code = 6'd0;
            {3'd2, 5'b00000}: w_code = 6'd8;
            {3'd2, 5'b00011}: w_code = 6'd12;
            {3'd2, 5'b00010}: w_code = 6'd13;
            {3'd3, 5'b00100}: w_code = 6'd3;
            {3'd3, 5'b00110}: w_code = 6'd6;
            {3'd3, 5'b00101}: w_code = 6'd10;
            {3'd3, 5'b00111}: w_code = 6'd14;
            {3'd3, 5'b00010}: w_code = 6'd17;
            {3'd3, 5'b00000}: w_code = 6'd18;
            {3'd3, 5'b00001}: w_code = 6'd20;
            {3'd3, 5'b00011}: w_code = 6'd22;
            {3'd4, 5'b01000}: w_code = 6'd1;
            {3'd4, 5'b01010}: w_code = 6'd2;
            {3'd4, 5'b00010}: w_code = 6'd5;
            {3'd4, 5'b00000}: w_code = 6'd7;
            {3'd4, 5'b00111}: w_code = 6'd9;
            {3'd4, 5'b00100}: w_code = 6'd11;
            {3'd4, 5'b00110}: w_code = 6'd15;
            {3'd4, 5'b01101}: w_code = 6'd16;
            {3'd4, 5'b00001}: w_code = 6'd21;
            {3'd4, 5'b01001}: w_code = 6'd23;
            {3'd4, 5'b01011}: w_code = 6'd24;
            {3'd4, 5'b01100}: w_code = 6'd25;
            {3'd5, 5'b11111}: w_code = 6'd26;
            {3'd5, 5'b01111}: w_code = 6'd27;
            {3'd5, 5'b00111}: w_code = 6'd28;
            {3'd5, 5'b00011}: w_code = 6'd29;
            {3'd5, 5'b00001}: w_code = 6'd30;
            {3'd5, 5'b00000}: w_code = 6'd31;
            {3'd5, 5'b10000}: w_code = 6'd32;
            {3'd5, 5'b11000}: w_code = 6'd33;
            {3'd5, 5'b11100}: w_code = 6'd34;
            {3'd5, 5'b11110}: w_code = 6'd35;
            default:          w_code = CODE_INVALID;
        endcase
    end

    assign char_data  = r_char_data;
    assign char_valid = r_char_valid;

endmodule

// File: tb/tb_morse_rx_core.sv
// Bench for morse_rx_core: directed vector table, hand-written corner sequences,
// and random stimulus against a string-based Morse reference model.
module tb_morse_rx_core;

    logic       clk = 1'b0;
    logic       rst, btn, bto, dto, ito, wto;
    logic       btn_res, dash_res, inter_res, word_res;
    logic [5:0] cdata;
    logic       cvalid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    morse_rx_core dut (
        .clk_100MHz  (clk),
        .reset       (rst),
        .user_btn    (btn),
        .btn_to      (bto),
        .dash_to     (dto),
        .inter_to    (ito),
        .word_to     (wto),
        .btn_to_res  (btn_res),
        .dash_to_res (dash_res),
        .inter_to_res(inter_res),
        .word_to_res (word_res),
        .char_data   (cdata),
        .char_valid  (cvalid)
    );

    typedef struct {
        logic       rst, btn, bto, dto, ito, wto;
        logic       ev;
        logic [5:0] ed;
        logic [3:0] eres;
    } vec_t;

    vec_t tbl [24];

    // res order: {btn_to_res, dash_to_res, inter_to_res, word_to_res}
    localparam logic [3:0] R_PRESS = 4'b0011;
    localparam logic [3:0] R_GAP   = 4'b1101;
    localparam logic [3:0] R_WAIT  = 4'b1110;
    localparam logic [3:0] R_OTHER = 4'b1111;

    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                          "--...", "---..", "----."};

    typedef enum {M_IDLE, M_PRESS, M_LOCK, M_GAP, M_EMIT, M_WAIT} mst_t;
    mst_t       m_st;
    string      m_elems;
    logic       m_valid;
    logic [5:0] m_data;

    function automatic logic [5:0] lookup(input string s);
        for (int i = 0; i < 36; i++)
            if (codes[i] == s) return 6'(i);
        return 6'd63;
    endfunction

    function automatic logic [3:0] res_of(input mst_t s);
        case (s)
            M_PRESS: return R_PRESS;
            M_GAP:   return R_GAP;
            M_WAIT:  return R_WAIT;
            default: return R_OTHER;
        endcase
    endfunction

    task automatic model_step();
        m_valid = 1'b0;
        if (rst) begin
            m_st = M_IDLE; m_elems = ""; m_data = 6'd0;
        end else begin
            case (m_st)
                M_IDLE:  if (btn) m_st = M_PRESS;
                M_PRESS: begin
                    if (bto) begin
                        m_elems = ""; m_st = M_LOCK;
                    end else if (!btn) begin
                        if (m_elems.len() < 6) m_elems = {m_elems, dto ? "-" : "."};
                        m_st = M_GAP;
                    end
                end
                M_LOCK:  if (!btn) m_st = M_IDLE;
                M_GAP: begin
                    if (ito) begin
                        m_valid = 1'b1; m_data = lookup(m_elems); m_st = M_EMIT;
                    end else if (btn) m_st = M_PRESS;
                end
                M_EMIT: begin
                    m_elems = "";
                    m_st = btn ? M_PRESS : M_WAIT;
                end
                M_WAIT: begin
                    if (btn) m_st = M_PRESS;
                    else if (wto) begin
                        m_valid = 1'b1; m_data = 6'd36; m_st = M_IDLE;
                    end
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [5:0] ed,
                         input logic [3:0] eres);
        logic [3:0] ares;
        ares = {btn_res, dash_res, inter_res, word_res};
        n_tests++;
        if (cvalid !== ev || cdata !== ed || ares !== eres) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b data=%0d res=%b, expected valid=%0b data=%0d res=%b",
                     name, cvalid, cdata, ares, ev, ed, eres);
        end
    endtask

    task automatic set_in(input logic r, input logic b, input logic bt, input logic d,
                          input logic i, input logic w);
        rst = r; btn = b; bto = bt; dto = d; ito = i; wto = w;
    endtask

    // Leaves the FSM in GAP with one more element buffered.
    task automatic press(input logic dash);
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, dash, 0, 0);
        tick();
        check("press_gap", 1'b0, cdata, R_GAP);
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0);
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 6'd0,  R_OTHER};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 6'd0,  R_PRESS};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 6'd0,  R_PRESS};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 6'd0,  R_GAP};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 6'd0,  R_PRESS};
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 6'd0,  R_GAP};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, 1, 6'd0,  R_OTHER};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 6'd0,  R_WAIT};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 6'd36, R_OTHER};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 6'd36, R_OTHER};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 6'd36, R_PRESS};
        tbl[11] = '{0, 1, 0, 1, 0, 0, 0, 6'd36, R_PRESS};
        tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 6'd36, R_GAP};
        tbl[13] = '{0, 1, 0, 0, 1, 0, 1, 6'd19, R_OTHER};
        tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 6'd19, R_PRESS};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 6'd19, R_GAP};
        tbl[16] = '{0, 0, 0, 0, 0, 1, 0, 6'd19, R_GAP};
        tbl[17] = '{0, 0, 0, 0, 1, 0, 1, 6'd4,  R_OTHER};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 6'd4,  R_WAIT};
        tbl[19] = '{0, 1, 0, 0, 0, 1, 0, 6'd4,  R_PRESS};
        tbl[20] = '{0, 1, 1, 0, 0, 0, 0, 6'd4,  R_OTHER};
        tbl[21] = '{0, 1, 0, 0, 0, 0, 0, 6'd4,  R_OTHER};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 6'd4,  R_OTHER};
        tbl[23] = '{0, 0, 0, 1, 1, 1, 0, 6'd4,  R_OTHER};

        for (int i = 0; i < 24; i++) begin
            set_in(tbl[i].rst, tbl[i].btn, tbl[i].bto, tbl[i].dto, tbl[i].ito, tbl[i].wto);
            tick();
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eres);
        end

        // Five dashes decode to '0', then the word gap emits a space.
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) press(1'b1);
        set_in(0, 0, 0, 0, 1, 0); tick();
        check("digit0", 1'b1, 6'd26, R_OTHER);
        set_in(0, 0, 0, 0, 0, 0); tick();
        check("digit0_wait", 1'b0, 6'd26, R_WAIT);
        set_in(0, 0, 0, 0, 0, 1); tick();
        check("space", 1'b1, 6'd36, R_OTHER);
        set_in(0, 0, 0, 0, 0, 0); tick();
        check("space_idle", 1'b0, 6'd36, R_OTHER);

        // Six elements overflow the buffer.
        for (int i = 0; i < 6; i++) press(1'b0);
        set_in(0, 0, 0, 0, 1, 0); tick();
        check("overflow", 1'b1, 6'd63, R_OTHER);
        set_in(0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 1); tick();
        check("overflow_space", 1'b1, 6'd36, R_OTHER);

        // Abort: a buffered dot must be discarded by the press timeout.
        press(1'b0);
        set_in(0, 1, 0, 0, 0, 0); tick();
        check("abort_press", 1'b0, 6'd36, R_PRESS);
        set_in(0, 1, 1, 0, 0, 0); tick();
        check("abort_lock", 1'b0, 6'd36, R_OTHER);
        set_in(0, 1, 0, 0, 1, 1); tick();
        check("abort_held", 1'b0, 6'd36, R_OTHER);
        set_in(0, 0, 0, 0, 0, 0); tick();
        check("abort_idle", 1'b0, 6'd36, R_OTHER);
        press(1'b0);
        set_in(0, 0, 0, 0, 1, 0); tick();
        check("abort_then_E", 1'b1, 6'd4, R_OTHER);
        set_in(0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 1); tick();

        // Reset in the middle of a press clears outputs and the buffered dash.
        press(1'b1);
        set_in(0, 1, 0, 0, 0, 0); tick();
        check("mid_press", 1'b0, 6'd36, R_PRESS);
        set_in(1, 1, 0, 1, 1, 1); tick();
        check("mid_press_rst", 1'b0, 6'd0, R_OTHER);
        set_in(0, 0, 0, 0, 0, 0); tick();
        check("after_rst_idle", 1'b0, 6'd0, R_OTHER);
        press(1'b0);
        set_in(0, 0, 0, 0, 1, 0); tick();
        check("after_rst_E", 1'b1, 6'd4, R_OTHER);

        // Random stimulus against the reference model.
        set_in(1, 0, 0, 0, 0, 0);
        model_step();
        tick();
        check("rand_rst", m_valid, m_data, res_of(m_st));
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 25) btn = ~btn;
            bto = ($urandom_range(0, 99) < 6);
            dto = ($urandom_range(0, 99) < 40);
            ito = ($urandom_range(0, 99) < 20);
            wto = ($urandom_range(0, 99) < 20);
            model_step();
            tick();
            check($sformatf("rand%0d", i), m_valid, m_data, res_of(m_st));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
